// File: rtl/tl_dma_copy_pkg.sv
// -----------------------------------------------------------------------------
// tl_dma_copy_pkg
//   Shared types and constants for the TileLink copy engine:
//   - beat geometry (BeatBytes / BeatSize) for a 128-bit TL data path
//   - TL-UL A/D channel opcode encodings
//   - copy-engine state enum
//   - small alignment helper
// -----------------------------------------------------------------------------
package tl_dma_copy_pkg;

    localparam int BeatBytes = 16;
    localparam int BeatSize  = 4;   // log2(BeatBytes); also the TL a_size value
    localparam int SizeWidth = 3;

    typedef enum logic [2:0] {
        TL_PUT_FULL_DATA    = 3'd0,
        TL_PUT_PARTIAL_DATA = 3'd1,
        TL_ARITHMETIC_DATA  = 3'd2,
        TL_LOGICAL_DATA     = 3'd3,
        TL_GET              = 3'd4,
        TL_INTENT           = 3'd5,
        TL_ACQUIRE_BLOCK    = 3'd6,
        TL_ACQUIRE_PERM     = 3'd7
    } tl_a_op_e;

    typedef enum logic [2:0] {
        TL_ACCESS_ACK      = 3'd0,
        TL_ACCESS_ACK_DATA = 3'd1,
        TL_HINT_ACK        = 3'd2,
        TL_GRANT           = 3'd4,
        TL_GRANT_DATA      = 3'd5,
        TL_RELEASE_ACK     = 3'd6
    } tl_d_op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_A  = 3'd1,
        GET_D  = 3'd2,
        PUT_A  = 3'd3,
        PUT_D  = 3'd4,
        FINISH = 3'd5
    } dma_state_e;

    // True when the low address/length bits within one beat are all zero.
    function automatic logic beat_aligned(input logic [BeatSize-1:0] low_bits);
        return (low_bits == '0);
    endfunction

endpackage

// File: rtl/tl_dma_copy.sv
// -----------------------------------------------------------------------------
// tl_dma_copy
//   TileLink initiator that copies a contiguous, beat-aligned memory region,
//   one beat at a time: single-beat Get, then PutFullData of the returned data.
//   Only one request is ever outstanding. The host never caches lines, so B is
//   drained (b_ready tied high) and C/E are never used.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   start_i               start pulse, honoured only while idle
//   src_i, dst_i, len_i   source / destination byte address, byte count
//   busy_o                high from accepted start until the cycle after done_o
//   done_o                one-cycle completion pulse (also on error)
//   error_o               sticky error, cleared by the next accepted start
//   host_a_*              TL A channel request (registered)
//   host_b_ready          tied 1
//   host_c_valid          tied 0
//   host_d_*              TL D channel response; host_d_ready tied 1
//   host_e_valid          tied 0
//
// State table
//   state  | meaning
//   IDLE   | waiting for start_i; busy_o drops here after FINISH
//   GET_A  | Get request presented, held until a_ready
//   GET_D  | waiting for AccessAckData, captures the beat
//   PUT_A  | PutFullData of the buffered beat, held until a_ready
//   PUT_D  | waiting for AccessAck; advances pointers and beat count
//   FINISH | pulses done_o, returns to IDLE
// -----------------------------------------------------------------------------
module tl_dma_copy
    import tl_dma_copy_pkg::*;
#(
    parameter int DataWidth   = 128,
    parameter int AddrWidth   = 38,
    parameter int SourceWidth = 3,
    parameter int SinkWidth   = 4,
    parameter int LenWidth    = 20
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   start_i,
    input  logic [AddrWidth-1:0]   src_i,
    input  logic [AddrWidth-1:0]   dst_i,
    input  logic [LenWidth-1:0]    len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,

    output logic                   host_a_valid,
    output logic [2:0]             host_a_opcode,
    output logic [2:0]             host_a_param,
    output logic [SizeWidth-1:0]   host_a_size,
    output logic [SourceWidth-1:0] host_a_source,
    output logic [AddrWidth-1:0]   host_a_address,
    output logic [DataWidth/8-1:0] host_a_mask,
    output logic [DataWidth-1:0]   host_a_data,
    output logic                   host_a_corrupt,
    input  logic                   host_a_ready,

    output logic                   host_b_ready,
    output logic                   host_c_valid,

    input  logic                   host_d_valid,
    input  logic [2:0]             host_d_opcode,
    input  logic [SizeWidth-1:0]   host_d_size,
    input  logic [SourceWidth-1:0] host_d_source,
    input  logic [SinkWidth-1:0]   host_d_sink,
    input  logic                   host_d_denied,
    input  logic [DataWidth-1:0]   host_d_data,
    input  logic                   host_d_corrupt,
    output logic                   host_d_ready,

    output logic                   host_e_valid
);

    localparam int                   BeatsWidth = LenWidth - BeatSize;
    localparam logic [AddrWidth-1:0] BeatIncr   = AddrWidth'(BeatBytes);

    dma_state_e            state;
    logic [AddrWidth-1:0]  cur_src;
    logic [AddrWidth-1:0]  cur_dst;
    logic [BeatsWidth-1:0] beats;
    logic [DataWidth-1:0]  beat_buf;

    logic start_ok;
    logic get_resp;
    logic put_resp;

    // D-channel fields the engine does not need: single source, no sink use.
    logic unused_d;
    assign unused_d = ^{host_d_size, host_d_source, host_d_sink};

    // Constant parts of every A request: full-beat, source 0, never corrupt.
    assign host_a_param   = 3'd0;
    assign host_a_size    = SizeWidth'(BeatSize);
    assign host_a_source  = '0;
    assign host_a_mask    = '1;
    assign host_a_corrupt = 1'b0;
    assign host_a_data    = beat_buf;

    assign host_b_ready = 1'b1;
    assign host_c_valid = 1'b0;
    assign host_d_ready = 1'b1;
    assign host_e_valid = 1'b0;

    assign start_ok = beat_aligned(src_i[BeatSize-1:0])
                   && beat_aligned(dst_i[BeatSize-1:0])
                   && beat_aligned(len_i[BeatSize-1:0]);

    // Responses only count in their wait state and with the matching opcode;
    // anything else is swallowed by the always-ready D channel.
    assign get_resp = host_d_valid && (host_d_opcode == TL_ACCESS_ACK_DATA);
    assign put_resp = host_d_valid && (host_d_opcode == TL_ACCESS_ACK);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cur_src        <= '0;
            cur_dst        <= '0;
            beats          <= '0;
            beat_buf       <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
            host_a_valid   <= 1'b0;
            host_a_opcode  <= TL_GET;
            host_a_address <= '0;
        end else begin
            done_o <= 1'b0;

            case (state)
                IDLE: begin
                    busy_o <= 1'b0;
                    if (start_i) begin
                        busy_o  <= 1'b1;
                        error_o <= 1'b0;
                        cur_src <= src_i;
                        cur_dst <= dst_i;
                        beats   <= len_i[LenWidth-1:BeatSize];
                        if (!start_ok) begin
                            error_o <= 1'b1;
                            state   <= FINISH;
                        end else if (len_i == '0) begin
                            state <= FINISH;
                        end else begin
                            host_a_valid   <= 1'b1;
                            host_a_opcode  <= TL_GET;
                            host_a_address <= src_i;
                            state          <= GET_A;
                        end
                    end
                end

                GET_A: begin
                    if (host_a_ready) begin
                        host_a_valid <= 1'b0;
                        state        <= GET_D;
                    end
                end

                GET_D: begin
                    if (get_resp) begin
                        beat_buf <= host_d_data;
                        if (host_d_denied || host_d_corrupt) begin
                            error_o <= 1'b1;
                            state   <= FINISH;
                        end else begin
                            host_a_valid   <= 1'b1;
                            host_a_opcode  <= TL_PUT_FULL_DATA;
                            host_a_address <= cur_dst;
                            state          <= PUT_A;
                        end
                    end
                end

                PUT_A: begin
                    if (host_a_ready) begin
                        host_a_valid <= 1'b0;
                        state        <= PUT_D;
                    end
                end

                PUT_D: begin
                    if (put_resp) begin
                        if (host_d_denied) begin
                            error_o <= 1'b1;
                            state   <= FINISH;
                        end else begin
                            cur_src <= cur_src + BeatIncr;
                            cur_dst <= cur_dst + BeatIncr;
                            beats   <= beats - BeatsWidth'(1);
                            if (beats == BeatsWidth'(1)) begin
                                state <= FINISH;
                            end else begin
                                host_a_valid   <= 1'b1;
                                host_a_opcode  <= TL_GET;
                                host_a_address <= cur_src + BeatIncr;
                                state          <= GET_A;
                            end
                        end
                    end
                end

                FINISH: begin
                    // busy_o stays high through the done_o cycle and is
                    // dropped by IDLE one cycle later.
                    done_o <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    host_a_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tl_dma_copy.sv
module tb_tl_dma_copy;
    import tl_dma_copy_pkg::*;

    localparam int AW = 38;
    localparam int DW = 128;
    localparam int LW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src, dst;
    logic [LW-1:0] len;
    logic          busy, done, error;

    logic            a_valid, a_ready, a_corrupt;
    logic [2:0]      a_opcode, a_param, a_size, a_source;
    logic [AW-1:0]   a_address;
    logic [DW/8-1:0] a_mask;
    logic [DW-1:0]   a_data;
    logic            b_ready, c_valid, e_valid;
    logic            d_valid, d_denied, d_corrupt, d_ready;
    logic [2:0]      d_opcode, d_size, d_source;
    logic [3:0]      d_sink;
    logic [DW-1:0]   d_data;

    always #5 clk = ~clk;

    tl_dma_copy dut (
        .clk_i(clk), .rst_i(rst),
        .start_i(start), .src_i(src), .dst_i(dst), .len_i(len),
        .busy_o(busy), .done_o(done), .error_o(error),
        .host_a_valid(a_valid), .host_a_opcode(a_opcode), .host_a_param(a_param),
        .host_a_size(a_size), .host_a_source(a_source), .host_a_address(a_address),
        .host_a_mask(a_mask), .host_a_data(a_data), .host_a_corrupt(a_corrupt),
        .host_a_ready(a_ready),
        .host_b_ready(b_ready), .host_c_valid(c_valid),
        .host_d_valid(d_valid), .host_d_opcode(d_opcode), .host_d_size(d_size),
        .host_d_source(d_source), .host_d_sink(d_sink), .host_d_denied(d_denied),
        .host_d_data(d_data), .host_d_corrupt(d_corrupt), .host_d_ready(d_ready),
        .host_e_valid(e_valid)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    // Source memory content is a fixed pattern of the address.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0], a[31:0] + 32'h0101_0101,
                {26'h0, a[37:32]} ^ 32'h5A5A_0000};
    endfunction

    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [2:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } a_exp_t;

    a_exp_t a_q[$];
    logic   err_q[$];

    task automatic exp_get(input logic [AW-1:0] a);
        a_q.push_back('{op: 3'd4, addr: a, data: '0});
    endtask

    task automatic exp_put(input logic [AW-1:0] a, input logic [DW-1:0] d);
        a_q.push_back('{op: 3'd0, addr: a, data: d});
    endtask

    task automatic exp_pair(input logic [AW-1:0] s, input logic [AW-1:0] d);
        exp_get(s);
        exp_put(d, pat(s));
    endtask

    // ---------------- memory responder ----------------
    int   get_cnt = 0, put_cnt = 0;
    int   deny_get_idx = -1, delay_put_idx = -1;
    logic bp_en = 1'b0;

    initial begin
        logic          pend_valid, in_req;
        int            pend_cnt, stall;
        logic [2:0]    pend_op;
        logic [DW-1:0] pend_data;
        logic          pend_denied;
        pend_valid = 1'b0; in_req = 1'b0; pend_cnt = 0; stall = 0;
        pend_op = 3'd0; pend_data = '0; pend_denied = 1'b0;
        a_ready = 1'b1; d_valid = 1'b0; d_opcode = 3'd0; d_size = 3'd4;
        d_source = 3'd0; d_sink = 4'd0; d_denied = 1'b0; d_data = '0; d_corrupt = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            d_valid  = 1'b0;
            d_denied = 1'b0;
            if (pend_valid) begin
                if (pend_cnt == 0) begin
                    d_valid    = 1'b1;
                    d_opcode   = pend_op;
                    d_data     = pend_data;
                    d_denied   = pend_denied;
                    pend_valid = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (a_valid) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    stall  = bp_en ? int'($urandom_range(0, 7)) : 0;
                end
                if (stall > 0) begin
                    a_ready = 1'b0;
                    stall--;
                end else begin
                    a_ready = 1'b1;
                end
            end else begin
                a_ready = !bp_en;
            end
            if (a_valid && a_ready) begin
                in_req     = 1'b0;
                pend_valid = 1'b1;
                if (a_opcode == 3'd4) begin
                    pend_op     = 3'd1;
                    pend_data   = rd_mem(a_address);
                    pend_denied = (get_cnt == deny_get_idx);
                    pend_cnt    = 0;
                    get_cnt++;
                end else begin
                    mem[a_address] = a_data;
                    pend_op     = 3'd0;
                    pend_data   = '0;
                    pend_denied = 1'b0;
                    pend_cnt    = (put_cnt == delay_put_idx) ? 8 : 0;
                    put_cnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int done_cnt = 0;
    int put_seen = 0;

    initial begin
        logic          prev_stall, busy_chk, e_err;
        logic [2:0]    p_op;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        a_exp_t        e;
        prev_stall = 1'b0; busy_chk = 1'b0;
        p_op = '0; p_addr = '0; p_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
                busy_chk   = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("a_valid_hold", 128'(a_valid), 128'(1'b1));
                    check("a_opcode_hold", 128'(a_opcode), 128'(p_op));
                    check("a_address_hold", 128'(a_address), 128'(p_addr));
                    check("a_data_hold", a_data, p_data);
                end
                if (busy_chk) begin
                    check("busy_fall", 128'(busy), 128'(1'b0));
                    busy_chk = 1'b0;
                end
                if (a_valid && a_ready) begin
                    if (a_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL a_unexpected: got op %0d addr %0h expected no request",
                                 a_opcode, a_address);
                    end else begin
                        e = a_q.pop_front();
                        check("a_opcode", 128'(a_opcode), 128'(e.op));
                        check("a_address", 128'(a_address), 128'(e.addr));
                        check("a_size", 128'(a_size), 128'(3'd4));
                        check("a_mask", 128'(a_mask), 128'(16'hFFFF));
                        if (e.op == 3'd0) begin
                            check("a_put_data", a_data, e.data);
                            put_seen++;
                        end
                    end
                end
                prev_stall = a_valid && !a_ready;
                p_op   = a_opcode;
                p_addr = a_address;
                p_data = a_data;
                if (done) begin
                    if (err_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL done_unexpected: got done_o=1 expected no completion");
                    end else begin
                        e_err = err_q.pop_front();
                        check("done_error", 128'(error), 128'(e_err));
                        check("done_busy", 128'(busy), 128'(1'b1));
                    end
                    busy_chk = 1'b1;
                    done_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int done_base;

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input logic [LW-1:0] l);
        done_base = done_cnt;
        step();
        start = 1'b1; src = s; dst = d; len = l;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int c = 0; c < 3000 && done_cnt == done_base; c++) step();
        if (done_cnt == done_base) fail_now(nm);
        repeat (3) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pbase;
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        repeat (3) step();
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_done", 128'(done), 128'(1'b0));
        check("rst_error", 128'(error), 128'(1'b0));
        check("rst_a_valid", 128'(a_valid), 128'(1'b0));
        check("rst_d_ready", 128'(d_ready), 128'(1'b1));
        rst = 1'b0;
        step();

        // 1: 64-byte copy, zero-latency memory
        exp_pair(38'h00_8000_0000, 38'h00_8000_1000);
        exp_pair(38'h00_8000_0010, 38'h00_8000_1010);
        exp_pair(38'h00_8000_0020, 38'h00_8000_1020);
        exp_pair(38'h00_8000_0030, 38'h00_8000_1030);
        err_q.push_back(1'b0);
        start_copy(38'h00_8000_0000, 38'h00_8000_1000, 20'd64);
        check("t1_busy_after_start", 128'(busy), 128'(1'b1));
        wait_done("t1_done");
        for (int i = 0; i < 4; i++)
            check("t1_mem", rd_mem(38'h00_8000_1000 + AW'(16 * i)),
                  pat(38'h00_8000_0000 + AW'(16 * i)));

        // 2: zero length, done two cycles after start, no TL traffic
        err_q.push_back(1'b0);
        done_base = done_cnt;
        step();
        start = 1'b1; src = 38'h00_8000_0000; dst = 38'h00_8000_1000; len = '0;
        step();
        start = 1'b0;
        check("t2_done_early", 128'(done), 128'(1'b0));
        check("t2_busy", 128'(busy), 128'(1'b1));
        step();
        check("t2_done", 128'(done), 128'(1'b1));
        wait_done("t2_done_wait");
        check("t2_error", 128'(error), 128'(1'b0));

        // 3: unaligned source, then unaligned length; error stays sticky
        err_q.push_back(1'b1);
        start_copy(38'h00_8000_0004, 38'h00_8000_1000, 20'd64);
        wait_done("t3_done");
        check("t3_error_sticky", 128'(error), 128'(1'b1));
        err_q.push_back(1'b1);
        start_copy(38'h00_8000_0000, 38'h00_8000_1000, 20'd20);
        wait_done("t3b_done");

        // 4: random a_ready backpressure, destination wraps past 2^38
        bp_en = 1'b1;
        exp_pair(38'h12_3456_7800, 38'h3F_FFFF_FFE0);
        exp_pair(38'h12_3456_7810, 38'h3F_FFFF_FFF0);
        exp_pair(38'h12_3456_7820, 38'h00_0000_0000);
        exp_pair(38'h12_3456_7830, 38'h00_0000_0010);
        err_q.push_back(1'b0);
        start_copy(38'h12_3456_7800, 38'h3F_FFFF_FFE0, 20'd64);
        check("t4_error_cleared", 128'(error), 128'(1'b0));
        wait_done("t4_done");
        check("t4_mem_wrap0", rd_mem(38'h00_0000_0000), pat(38'h12_3456_7820));
        check("t4_mem_wrap1", rd_mem(38'h00_0000_0010), pat(38'h12_3456_7830));
        bp_en = 1'b0;

        // 5: second Get denied -> exactly one Put, error
        deny_get_idx = get_cnt + 1;
        pbase = put_seen;
        exp_pair(38'h00_9000_0000, 38'h00_9000_2000);
        exp_get(38'h00_9000_0010);
        err_q.push_back(1'b1);
        start_copy(38'h00_9000_0000, 38'h00_9000_2000, 20'd48);
        wait_done("t5_done");
        check("t5_put_count", 128'(put_seen - pbase), 128'(1));
        check("t5_error", 128'(error), 128'(1'b1));
        deny_get_idx = -1;

        // 6: reset while waiting for the 3rd Put ack, late ack dropped
        delay_put_idx = put_cnt + 2;
        pbase = put_seen;
        exp_pair(38'h00_A000_0000, 38'h00_A000_4000);
        exp_pair(38'h00_A000_0010, 38'h00_A000_4010);
        exp_pair(38'h00_A000_0020, 38'h00_A000_4020);
        start_copy(38'h00_A000_0000, 38'h00_A000_4000, 20'd64);
        for (int c = 0; c < 500 && put_seen < pbase + 3; c++) step();
        if (put_seen < pbase + 3) fail_now("t6_third_put");
        step();
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 128'(busy), 128'(1'b0));
        check("t6_rst_done", 128'(done), 128'(1'b0));
        check("t6_rst_error", 128'(error), 128'(1'b0));
        check("t6_rst_a_valid", 128'(a_valid), 128'(1'b0));
        check("t6_rst_d_ready", 128'(d_ready), 128'(1'b1));
        step();
        step();
        rst = 1'b0;
        repeat (14) step();
        check("t6_idle_busy", 128'(busy), 128'(1'b0));
        check("t6_idle_a_valid", 128'(a_valid), 128'(1'b0));
        check("t6_a_queue_empty", 128'(a_q.size()), 128'(0));
        delay_put_idx = -1;
        exp_pair(38'h00_B000_0000, 38'h00_B000_8000);
        exp_pair(38'h00_B000_0010, 38'h00_B000_8010);
        err_q.push_back(1'b0);
        start_copy(38'h00_B000_0000, 38'h00_B000_8000, 20'd32);
        wait_done("t6b_done");
        check("t6b_mem0", rd_mem(38'h00_B000_8000), pat(38'h00_B000_0000));
        check("t6b_mem1", rd_mem(38'h00_B000_8010), pat(38'h00_B000_0010));
        check("end_a_queue", 128'(a_q.size()), 128'(0));
        check("end_err_queue", 128'(err_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
